cache_arbiter: RTL and testbench
================================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter LINE_W, default 256, cacheline width in bits.
REQ-002 Parameter ADDR_W, default 32, physical address width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 i_read  input  1  icache line-fill request; held until i_resp.
REQ-006 i_addr  input  ADDR_W  icache line address.
REQ-007 i_rdata  output  LINE_W  line returned to icache.
REQ-008 i_resp  output  1  one-cycle completion pulse to icache.
REQ-009 d_read, d_write  input  1 each  dcache fill / writeback request; mutually exclusive; held until d_resp.
REQ-010 d_addr  input  ADDR_W  dcache line address.
REQ-011 d_wdata  input  LINE_W  writeback line.
REQ-012 d_rdata  output  LINE_W  line returned to dcache.
REQ-013 d_resp  output  1  one-cycle completion pulse to dcache.
REQ-014 m_read, m_write  output  1 each  request to the memory-side line adaptor.
REQ-015 m_addr  output  ADDR_W; m_wdata  output  LINE_W.
REQ-016 m_rdata  input  LINE_W; m_resp  input  1  memory completion pulse.

Function
REQ-017 The FSM SHALL have states IDLE, I_BUSY, D_BUSY, DONE.
REQ-018 In IDLE with any request pending, the arbiter SHALL grant one requester, latch its address (and d_wdata for writes) into internal registers, and enter I_BUSY or D_BUSY on the next edge.
REQ-019 m_read/m_write/m_addr/m_wdata SHALL be driven only from registered state; m_read or m_write asserts in the cycle after the grant decision and stays constant until m_resp.
REQ-020 On m_resp in I_BUSY/D_BUSY, the arbiter SHALL register m_rdata into the owner's rdata output, pulse that owner's resp for exactly one cycle, deassert m_read/m_write in that same cycle, and enter DONE.
REQ-021 DONE SHALL last one cycle with no grant, so the requester drops its request before re-arbitration; DONE then goes to IDLE.
REQ-022 The non-owner's resp SHALL stay 0 and its rdata SHALL hold its last value.
REQ-023 Requests arriving or changing while busy SHALL be ignored until IDLE; the latched address is not affected by requester input changes.
REQ-024 Simultaneous i and d requests in IDLE SHALL be resolved per REQ-030/031.
REQ-025 A d_read and d_write asserted together is illegal; the bench SHALL flag it as an assertion error; the RTL SHALL treat it as d_write.
REQ-026 Minimum turnaround: request visible in cycle N, m_resp in cycle M -> resp pulse in cycle M+1, next grant decision no earlier than cycle M+2.

Reset
REQ-027 While rst=0 the FSM SHALL be IDLE; m_read, m_write, i_resp, d_resp = 0; m_addr, m_wdata, i_rdata, d_rdata = 0; the priority pointer points to dcache.
REQ-028 Reset asserted mid-transaction SHALL abandon it immediately with no resp pulse; a late m_resp after reset release SHALL be ignored in IDLE.

Configuration
REQ-029 Macro CACHE_ARB_RR_EN selects the arbitration policy.
REQ-030 Without CACHE_ARB_RR_EN: fixed priority, dcache wins every tie.
REQ-031 With CACHE_ARB_RR_EN: a one-bit last-served pointer, updated at each grant; a tie goes to the requester not served last; no starvation beyond one transaction.

Structure
REQ-032 Package arb_types SHALL hold the arb_state_t enum and the arb_owner_t enum (ARB_I, ARB_D).
REQ-033 Sub-module arb_pick SHALL be combinational; it takes the two request bits and the pointer, and returns the grant and owner.
REQ-034 Everything else SHALL be one always_ff FSM/datapath register block with combinational output decode.

Verification
REQ-035 i_read only, i_addr=0x0000_0040, m_resp 5 cycles later with m_rdata=0xA5 repeated -> m_read=1 with m_addr=0x40, then i_resp one cycle with i_rdata=0xA5.. and d_resp=0.
REQ-036 i_read and d_write in the same cycle, d_addr=0x100, fixed priority -> m_write first with m_addr=0x100 and m_wdata=d_wdata; after d_resp and DONE, m_read with m_addr=i_addr.
REQ-037 CACHE_ARB_RR_EN, both requesting continuously for 4 transactions -> owners alternate D, I, D, I.
REQ-038 Change i_addr from 0x40 to 0x80 while I_BUSY -> m_addr stays 0x40 until m_resp.
REQ-039 Pull rst low mid-D_BUSY, then pulse m_resp after release -> all outputs 0, no resp pulse, FSM IDLE.
REQ-040 Hold m_resp high for 2 consecutive cycles -> exactly one resp pulse (the second lands in DONE and is ignored).

Source files
------------

// File: rtl/arb_types.sv
// rtl/arb_types.sv - shared types for the cache arbiter
// Purpose: FSM state and owner enums used by cache_arbiter and arb_pick.
// Ports: none (package).
package arb_types;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  typedef enum logic {
    ARB_I = 1'b0,
    ARB_D = 1'b1
  } arb_owner_t;

  // The requester that did not win; used to rotate the tie-break pointer.
  function automatic arb_owner_t arb_other(input arb_owner_t owner);
    return (owner == ARB_D) ? ARB_I : ARB_D;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational two-way grant picker
// Purpose: grants one of the icache/dcache requests; a tie goes to i_prio.
// Ports:
//   i_ireq   icache request
//   i_dreq   dcache request
//   i_prio   owner that wins a tie
//   o_grant  any request present
//   o_owner  granted owner (meaningful only when o_grant=1)
module arb_pick
  import arb_types::*;
(
  input  logic       i_ireq,
  input  logic       i_dreq,
  input  arb_owner_t i_prio,
  output logic       o_grant,
  output arb_owner_t o_owner
);

  always_comb begin
    o_grant = i_ireq | i_dreq;
    o_owner = i_prio;
    if (i_ireq && !i_dreq) begin
      o_owner = ARB_I;
    end else if (i_dreq && !i_ireq) begin
      o_owner = ARB_D;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - icache/dcache arbiter in front of one memory line port
// Purpose: grants one cache at a time to the memory-side line adaptor,
//   latches the request, returns the line and a one-cycle resp pulse.
// Configuration: define CACHE_ARB_RR_EN for round-robin tie-break;
//   otherwise dcache wins every tie.
// Ports:
//   clk, rst                   clock, async active-low reset
//   i_read, i_addr             icache fill request / line address
//   i_rdata, i_resp            icache returned line / completion pulse
//   d_read, d_write, d_addr    dcache fill or writeback request / address
//   d_wdata                    dcache writeback line
//   d_rdata, d_resp            dcache returned line / completion pulse
//   m_read, m_write, m_addr    registered memory-side request
//   m_wdata                    registered memory-side write line
//   m_rdata, m_resp            memory returned line / completion pulse
module cache_arbiter
  import arb_types::*;
#(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [LINE_W-1:0] m_wdata,
  input  logic [LINE_W-1:0] m_rdata,
  input  logic              m_resp
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  arb_owner_t        r_prio;
  logic              r_m_read;
  logic              r_m_write;
  logic [ADDR_W-1:0] r_m_addr;
  logic [LINE_W-1:0] r_m_wdata;
  logic [LINE_W-1:0] r_i_rdata;
  logic [LINE_W-1:0] r_d_rdata;
  logic              r_i_resp;
  logic              r_d_resp;

  logic              w_d_req;
  logic              w_grant;
  arb_owner_t        w_owner;

  assign w_d_req = d_read | d_write;

  arb_pick u_pick (
    .i_ireq  (i_read),
    .i_dreq  (w_d_req),
    .i_prio  (r_prio),
    .o_grant (w_grant),
    .o_owner (w_owner)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_state_nxt = (w_owner == ARB_D) ? D_BUSY : I_BUSY;
        end
      end
      I_BUSY, D_BUSY: begin
        if (m_resp) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_prio    <= ARB_D;
      r_m_read  <= 1'b0;
      r_m_write <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_i_resp  <= 1'b0;
      r_d_resp  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_i_resp <= 1'b0;
      r_d_resp <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            if (w_owner == ARB_D) begin
              r_m_addr <= d_addr;
              // d_read together with d_write is illegal; write takes precedence.
              if (d_write) begin
                r_m_write <= 1'b1;
                r_m_wdata <= d_wdata;
              end else begin
                r_m_read <= 1'b1;
              end
            end else begin
              r_m_addr <= i_addr;
              r_m_read <= 1'b1;
            end
`ifdef CACHE_ARB_RR_EN
            r_prio <= arb_other(w_owner);
`endif
          end
        end
        I_BUSY: begin
          if (m_resp) begin
            r_i_rdata <= m_rdata;
            r_i_resp  <= 1'b1;
            r_m_read  <= 1'b0;
            r_m_write <= 1'b0;
          end
        end
        D_BUSY: begin
          if (m_resp) begin
            r_d_rdata <= m_rdata;
            r_d_resp  <= 1'b1;
            r_m_read  <= 1'b0;
            r_m_write <= 1'b0;
          end
        end
        // DONE: one dead cycle so the served cache can drop its request.
        default: ;
      endcase
    end
  end

  assign m_read  = r_m_read;
  assign m_write = r_m_write;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;
  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;
  assign i_resp  = r_i_resp;
  assign d_resp  = r_d_resp;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - scoreboard bench for cache_arbiter
module tb_cache_arbiter;
  import arb_types::*;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          m_read;
  logic          m_write;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;
  logic [LW-1:0] m_rdata = '0;
  logic          m_resp = 1'b0;

  cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_resp(m_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } mem_exp_t;

  typedef struct {
    arb_owner_t    owner;
    logic [LW-1:0] data;
  } resp_exp_t;

  mem_exp_t  mem_q[$];
  resp_exp_t resp_q[$];
  int checks = 0;
  int errors = 0;

  localparam logic [LW-1:0] LINE_A5 = {32{8'hA5}};
  localparam logic [LW-1:0] LINE_E5 = {32{8'hE5}};
  localparam logic [LW-1:0] LINE_25 = {32{8'h25}};
  localparam logic [LW-1:0] WB_1    = {8{32'hDEAD_BEEF}};
  localparam logic [LW-1:0] WB_2    = {8{32'h1234_5678}};

  function automatic void chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic void push_mem(input logic wr, input logic [AW-1:0] addr, input logic [LW-1:0] wdata);
    mem_exp_t e;
    e.wr = wr; e.addr = addr; e.wdata = wdata;
    mem_q.push_back(e);
  endfunction

  function automatic void push_resp(input arb_owner_t owner, input logic [LW-1:0] data);
    resp_exp_t e;
    e.owner = owner; e.data = data;
    resp_q.push_back(e);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Memory-side responder: waits for a request, then returns a line whose
  // bytes are the low address byte XOR 0xE5, holding m_resp for 'hold' cycles.
  task automatic serve(input int delay, input int hold);
    int t;
    t = 0;
    while (!(m_read || m_write) && t < 50) begin
      tick(1);
      t++;
    end
    if (!(m_read || m_write)) begin
      checks++;
      errors++;
      $display("FAIL mem_wait actual=no_request required=request");
      return;
    end
    tick(delay);
    m_resp  = 1'b1;
    m_rdata = {32{m_addr[7:0] ^ 8'hE5}};
    tick(hold);
    m_resp = 1'b0;
  endtask

  // Monitor / scoreboard.
  initial begin
    logic          prev_req;
    logic          prev_resp;
    logic          w_req;
    int            cyc;
    int            last_resp_cyc;
    logic [AW-1:0] cur_addr;
    logic [LW-1:0] last_i;
    logic [LW-1:0] last_d;
    mem_exp_t      me;
    resp_exp_t     re;
    prev_req = 1'b0; prev_resp = 1'b0; cyc = 0; last_resp_cyc = -100;
    cur_addr = '0; last_i = '0; last_d = '0;
    forever begin
      @(negedge clk);
      cyc++;
      assert (!(d_read && d_write)) else $error("illegal d_read with d_write");
      if (!rst) begin
        chk("rst_ctrl", LW'({m_read, m_write, i_resp, d_resp}), '0);
        chk("rst_m_addr", LW'(m_addr), '0);
        chk("rst_m_wdata", m_wdata, '0);
        chk("rst_i_rdata", i_rdata, '0);
        chk("rst_d_rdata", d_rdata, '0);
        last_i = '0; last_d = '0; prev_req = 1'b0; prev_resp = 1'b0;
      end else begin
        w_req = m_read | m_write;
        if (w_req && !prev_req) begin
          chk("turnaround", LW'((cyc - last_resp_cyc) >= 2), LW'(1));
          if (mem_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mem_unexpected actual=addr_%0h required=none", m_addr);
          end else begin
            me = mem_q.pop_front();
            chk("m_write", LW'(m_write), LW'(me.wr));
            chk("m_read", LW'(m_read), LW'(!me.wr));
            chk("m_addr", LW'(m_addr), LW'(me.addr));
            if (me.wr) chk("m_wdata", m_wdata, me.wdata);
          end
          cur_addr = m_addr;
        end else if (w_req) begin
          chk("m_addr_hold", LW'(m_addr), LW'(cur_addr));
        end
        prev_req = w_req;
        if (i_resp || d_resp) begin
          chk("resp_single", LW'({i_resp & d_resp, prev_resp}), '0);
          if (resp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL resp_unexpected actual=i%0b_d%0b required=none", i_resp, d_resp);
          end else begin
            re = resp_q.pop_front();
            chk("resp_owner", LW'(d_resp ? ARB_D : ARB_I), LW'(re.owner));
            if (re.owner == ARB_D) last_d = re.data;
            else last_i = re.data;
          end
          last_resp_cyc = cyc;
        end
        chk("i_rdata", i_rdata, last_i);
        chk("d_rdata", d_rdata, last_d);
        prev_resp = i_resp | d_resp;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    tick(3);
    rst = 1'b1;
    tick(1);

    // Single icache fill.
    push_mem(1'b0, 32'h40, '0);
    push_resp(ARB_I, LINE_A5);
    i_addr = 32'h40;
    i_read = 1'b1;
    tick(1);
    chk("grant_latency", LW'(m_read), LW'(1));
    serve(5, 1);
    i_read = 1'b0;
    tick(2);

    // Tie: dcache writeback first, then icache fill.
    push_mem(1'b1, 32'h100, WB_1);
    push_resp(ARB_D, LINE_E5);
    push_mem(1'b0, 32'h40, '0);
    push_resp(ARB_I, LINE_A5);
    d_addr  = 32'h100;
    d_wdata = WB_1;
    d_write = 1'b1;
    i_read  = 1'b1;
    serve(3, 1);
    d_write = 1'b0;
    serve(2, 1);
    i_read = 1'b0;
    tick(2);

    // Address change while busy must not disturb the latched address.
    push_mem(1'b0, 32'h40, '0);
    push_resp(ARB_I, LINE_A5);
    i_addr = 32'h40;
    i_read = 1'b1;
    tick(2);
    i_addr = 32'h80;
    serve(4, 1);
    i_read = 1'b0;
    tick(2);

    // Both requesting continuously for four transactions.
    i_addr = 32'h40;
    d_addr = 32'h100;
    for (int k = 0; k < 4; k++) begin
`ifdef CACHE_ARB_RR_EN
      if (k % 2 == 0) begin
        push_mem(1'b0, 32'h100, '0);
        push_resp(ARB_D, LINE_E5);
      end else begin
        push_mem(1'b0, 32'h40, '0);
        push_resp(ARB_I, LINE_A5);
      end
`else
      push_mem(1'b0, 32'h100, '0);
      push_resp(ARB_D, LINE_E5);
`endif
    end
    d_read = 1'b1;
    i_read = 1'b1;
    for (int k = 0; k < 4; k++) serve(2, 1);
    d_read = 1'b0;
    i_read = 1'b0;
    tick(3);

    // m_resp held two cycles: only one resp pulse.
    push_mem(1'b0, 32'hC0, '0);
    push_resp(ARB_I, LINE_25);
    i_addr = 32'hC0;
    i_read = 1'b1;
    serve(3, 2);
    i_read = 1'b0;
    tick(3);

    // Reset mid-D_BUSY, then a late m_resp in IDLE.
    push_mem(1'b1, 32'h200, WB_2);
    d_addr  = 32'h200;
    d_wdata = WB_2;
    d_write = 1'b1;
    tick(3);
    rst     = 1'b0;
    d_write = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
    m_resp  = 1'b1;
    m_rdata = {32{8'h77}};
    tick(1);
    m_resp = 1'b0;
    tick(3);
    chk("fsm_idle", LW'(dut.r_state), LW'(IDLE));
    chk("post_rst_mreq", LW'({m_read, m_write}), '0);

    chk("mem_q_empty", LW'(mem_q.size()), '0);
    chk("resp_q_empty", LW'(resp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
